// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: drives a req/gnt/rvalid data bus and extends load data.
// Optional watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            MemCtrlM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  BusErrM
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  lat_lo_q;
  logic [2:0]  lat_ctrl_q;

  logic        access_c, is_byte_c, is_half_c, misalign_c, start_c;
  logic        timeout_c, to_fire_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  lane_byte_c;
  logic [15:0] lane_half_c;
  logic [31:0] load_ext_c;

  // Request decode from the E/M register outputs
  always_comb begin
    access_c   = MemReadM | MemWriteM;
    is_byte_c  = (MemCtrlM[1:0] == 2'b00);
    is_half_c  = (MemCtrlM[1:0] == 2'b01);
    misalign_c = (is_half_c && ALUResultM[0]) ||
                 (!is_byte_c && !is_half_c && (ALUResultM[1:0] != 2'b00));
    start_c    = (state_q == S_IDLE) && access_c && !misalign_c;
  end

  assign MisalignM = (state_q == S_IDLE) && access_c && misalign_c;
  assign StallM    = start_c || (state_q == S_REQ) || (state_q == S_WAIT);

  // Store lane steering; loads carry the same enables for the selected size
  always_comb begin
    be_c    = 4'hF;
    wdata_c = WriteDataM;
    if (is_byte_c) begin
      be_c    = 4'b0001 << ALUResultM[1:0];
      wdata_c = {4{WriteDataM[7:0]}};
    end else if (is_half_c) begin
      be_c    = 4'b0011 << {ALUResultM[1], 1'b0};
      wdata_c = {2{WriteDataM[15:0]}};
    end
  end

  // Load lane select and extension using the latched offset and size
  always_comb begin
    lane_byte_c = mem_rdata[7:0];
    case (lat_lo_q)
      2'd1:    lane_byte_c = mem_rdata[15:8];
      2'd2:    lane_byte_c = mem_rdata[23:16];
      2'd3:    lane_byte_c = mem_rdata[31:24];
      default: lane_byte_c = mem_rdata[7:0];
    endcase
    lane_half_c = lat_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext_c  = mem_rdata;
    if (lat_ctrl_q[1:0] == 2'b00) begin
      load_ext_c = lat_ctrl_q[2] ? {24'h0, lane_byte_c}
                                 : {{24{lane_byte_c[7]}}, lane_byte_c};
    end else if (lat_ctrl_q[1:0] == 2'b01) begin
      load_ext_c = lat_ctrl_q[2] ? {16'h0, lane_half_c}
                                 : {{16{lane_half_c[15]}}, lane_half_c};
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  assign timeout_c = ((state_q == S_REQ) || (state_q == S_WAIT)) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared on entry to REQ, counts every REQ/WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start_c) begin
      cnt_q <= '0;
    end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_c          = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a bus response in the same cycle wins over the watchdog
  always_comb begin
    state_d   = state_q;
    to_fire_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_c) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = mem_we ? S_DONE : S_WAIT;
        end else if (timeout_c) begin
          state_d   = S_DONE;
          to_fire_c = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_DONE;
        end else if (timeout_c) begin
          state_d   = S_DONE;
          to_fire_c = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered bus outputs and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= 4'h0;
      ReadDataM  <= '0;
      BusErrM    <= 1'b0;
      lat_lo_q   <= 2'b00;
      lat_ctrl_q <= 3'b000;
    end else begin
      mem_req <= (state_d == S_REQ);
      BusErrM <= to_fire_c;
      if (start_c) begin
        mem_we     <= MemWriteM && !MemReadM;
        mem_addr   <= {ALUResultM[31:2], 2'b00};
        mem_wdata  <= wdata_c;
        mem_be     <= be_c;
        lat_lo_q   <= ALUResultM[1:0];
        lat_ctrl_q <= MemCtrlM;
      end
      if ((state_q == S_WAIT) && mem_rvalid) begin
        ReadDataM <= load_ext_c;
      end else if (to_fire_c && !mem_we) begin
        ReadDataM <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: decode table, transaction table, reset and watchdog sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALUResultM, WriteDataM;
  logic        MemReadM, MemWriteM;
  logic [2:0]  MemCtrlM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemCtrlM(MemCtrlM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic        mis;
    logic        stall;
  } dec_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    int          rvd;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic        ewe;
    logic [31:0] erd;
    int          estall;
    int          ereqs;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; MemCtrlM = 3'b010;
    ALUResultM = 32'h0; WriteDataM = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // Runs one access from IDLE; returns at posedge+2 of the DONE cycle
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gd, input int rvd,
                         input logic [3:0] ebe, input logic [31:0] ewd, input logic ewe,
                         output int stall, output int reqs, output logic berr_done);
    bit granted = 0;
    bit rv_done = 0;
    bit done    = 0;
    int req_i   = 0;
    int wait_i  = 0;
    stall = 0; reqs = 0; berr_done = 1'b0;
    MemReadM = rd; MemWriteM = wr; MemCtrlM = ctrl;
    ALUResultM = addr; WriteDataM = wdata; mem_rdata = rdata;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (mem_req) begin
        reqs++;
        chk("req_addr", mem_addr, {addr[31:2], 2'b00});
        chk("req_be", 32'(mem_be), 32'(ebe));
        chk("req_wdata", mem_wdata, ewd);
        chk("req_we", 32'(mem_we), 32'(ewe));
        if (req_i == gd) begin
          mem_gnt = 1'b1;
          granted = 1;
        end
        req_i++;
      end else if (granted && rd && !rv_done) begin
        if (wait_i == rvd) begin
          mem_rvalid = 1'b1;
          rv_done = 1;
        end
        wait_i++;
      end
      #1;
      if (StallM) begin
        stall++;
        @(posedge clk); #1;
      end else begin
        done = 1;
        berr_done = BusErrM;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL txn_budget actual=stall_stuck required=done");
    end
  endtask

  task automatic finish_txn();
    idle_inputs();
    @(posedge clk); #1;
  endtask

  dec_t dv[12];
  txn_t tv[11];
  int   st, rq;
  logic be_done;

  initial begin
    dv[0]  = '{1'b1, 1'b0, 3'b001, 32'h3001, 1'b1, 1'b0};
    dv[1]  = '{1'b1, 1'b0, 3'b010, 32'h3002, 1'b1, 1'b0};
    dv[2]  = '{1'b1, 1'b0, 3'b010, 32'h3000, 1'b0, 1'b1};
    dv[3]  = '{1'b1, 1'b0, 3'b101, 32'h3003, 1'b1, 1'b0};
    dv[4]  = '{1'b1, 1'b0, 3'b101, 32'h3002, 1'b0, 1'b1};
    dv[5]  = '{1'b1, 1'b0, 3'b000, 32'h3003, 1'b0, 1'b1};
    dv[6]  = '{1'b0, 1'b1, 3'b010, 32'h3001, 1'b1, 1'b0};
    dv[7]  = '{1'b0, 1'b1, 3'b001, 32'h3002, 1'b0, 1'b1};
    dv[8]  = '{1'b1, 1'b0, 3'b011, 32'h3002, 1'b1, 1'b0};
    dv[9]  = '{1'b1, 1'b0, 3'b110, 32'h3001, 1'b1, 1'b0};
    dv[10] = '{1'b0, 1'b0, 3'b010, 32'h3001, 1'b0, 1'b0};
    dv[11] = '{1'b1, 1'b0, 3'b111, 32'h3004, 1'b0, 1'b1};

    tv[0]  = '{1'b0, 1'b1, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 0, 0,
               4'b1000, 32'hA5A5A5A5, 1'b1, 32'h00000000, 2, 1};
    tv[1]  = '{1'b1, 1'b0, 3'b000, 32'h2002, 32'h0, 32'h1280FFFF, 0, 0,
               4'b0100, 32'h0, 1'b0, 32'hFFFFFF80, 3, 1};
    tv[2]  = '{1'b1, 1'b0, 3'b100, 32'h2002, 32'h0, 32'h1280FFFF, 0, 0,
               4'b0100, 32'h0, 1'b0, 32'h00000080, 3, 1};
    tv[3]  = '{1'b0, 1'b1, 3'b001, 32'h4006, 32'hDEADBEEF, 32'h0, 0, 0,
               4'b1100, 32'hBEEFBEEF, 1'b1, 32'h00000080, 2, 1};
    tv[4]  = '{1'b1, 1'b0, 3'b001, 32'h4002, 32'h0, 32'h80017FFF, 0, 0,
               4'b1100, 32'h0, 1'b0, 32'hFFFF8001, 3, 1};
    tv[5]  = '{1'b1, 1'b0, 3'b101, 32'h4000, 32'h0, 32'h80017FFF, 0, 0,
               4'b0011, 32'h0, 1'b0, 32'h00007FFF, 3, 1};
    tv[6]  = '{1'b1, 1'b0, 3'b010, 32'h5000, 32'h11223344, 32'hCAFEF00D, 3, 1,
               4'b1111, 32'h11223344, 1'b0, 32'hCAFEF00D, 7, 4};
    tv[7]  = '{1'b0, 1'b1, 3'b010, 32'h6004, 32'h0BADF00D, 32'h0, 1, 0,
               4'b1111, 32'h0BADF00D, 1'b1, 32'hCAFEF00D, 3, 2};
    tv[8]  = '{1'b1, 1'b1, 3'b000, 32'h7001, 32'h00000055, 32'h00007F00, 0, 0,
               4'b0010, 32'h55555555, 1'b0, 32'h0000007F, 3, 1};
    tv[9]  = '{1'b1, 1'b0, 3'b111, 32'h8000, 32'h0, 32'h89ABCDEF, 0, 2,
               4'b1111, 32'h0, 1'b0, 32'h89ABCDEF, 5, 1};
    tv[10] = '{1'b0, 1'b1, 3'b000, 32'h9000, 32'h000001FF, 32'h0, 2, 0,
               4'b0001, 32'hFFFFFFFF, 1'b1, 32'h89ABCDEF, 4, 3};

    rst_n = 1'b0;
    mem_rdata = 32'h0;
    idle_inputs();
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_readdata", ReadDataM, 32'h0);
    chk("rst_buserr", 32'(BusErrM), 32'h0);
    chk("rst_stall", 32'(StallM), 32'h0);
    chk("rst_misalign", 32'(MisalignM), 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode table: each vector shown for part of one cycle, removed before the edge
    foreach (dv[i]) begin
      MemReadM = dv[i].rd; MemWriteM = dv[i].wr; MemCtrlM = dv[i].ctrl; ALUResultM = dv[i].addr;
      #1;
      chk($sformatf("dec%0d_misalign", i), 32'(MisalignM), 32'(dv[i].mis));
      chk($sformatf("dec%0d_stall", i), 32'(StallM), 32'(dv[i].stall));
      idle_inputs();
      @(posedge clk); #1;
      chk($sformatf("dec%0d_noreq", i), 32'(mem_req), 32'h0);
    end

    // Misaligned LH held for several cycles never reaches the bus
    MemReadM = 1'b1; MemCtrlM = 3'b001; ALUResultM = 32'h3001;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("mis_hold_req", 32'(mem_req), 32'h0);
      chk("mis_hold_stall", 32'(StallM), 32'h0);
      chk("mis_hold_flag", 32'(MisalignM), 32'h1);
    end
    finish_txn();

    foreach (tv[i]) begin
      run_txn(tv[i].rd, tv[i].wr, tv[i].ctrl, tv[i].addr, tv[i].wdata, tv[i].rdata,
              tv[i].gd, tv[i].rvd, tv[i].be, tv[i].ewd, tv[i].ewe, st, rq, be_done);
      chk($sformatf("txn%0d_readdata", i), ReadDataM, tv[i].erd);
      chk($sformatf("txn%0d_stall_cycles", i), 32'(st), 32'(tv[i].estall));
      chk($sformatf("txn%0d_req_cycles", i), 32'(rq), 32'(tv[i].ereqs));
      chk($sformatf("txn%0d_buserr", i), 32'(be_done), 32'h0);
      chk($sformatf("txn%0d_done_req", i), 32'(mem_req), 32'h0);
      finish_txn();
    end

    // Reset asserted while a load waits in WAIT, then a stray rvalid
    MemReadM = 1'b1; MemCtrlM = 3'b010; ALUResultM = 32'hB000;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; MemReadM = 1'b0;
    chk("wait_stall", 32'(StallM), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'h0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_mem_be", 32'(mem_be), 32'h0);
    chk("arst_mem_wdata", mem_wdata, 32'h0);
    chk("arst_mem_we", 32'(mem_we), 32'h0);
    chk("arst_readdata", ReadDataM, 32'h0);
    chk("arst_stall", 32'(StallM), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rdata = 32'hFFFFFFFF; mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("stray_rv_readdata", ReadDataM, 32'h0);
    chk("stray_rv_stall", 32'(StallM), 32'h0);
    @(posedge clk); #1;
    chk("stray_rv_req", 32'(mem_req), 32'h0);
    chk("stray_rv_readdata2", ReadDataM, 32'h0);

    run_txn(1'b1, 1'b0, 3'b010, 32'hA000, 32'h0, 32'h12345678, 0, 0,
            4'hF, 32'h0, 1'b0, st, rq, be_done);
    chk("pre_wd_readdata", ReadDataM, 32'h12345678);
    finish_txn();

`ifdef MEM_TIMEOUT_EN
    // Grant never arrives: watchdog ends the load after four REQ cycles
    run_txn(1'b1, 1'b0, 3'b010, 32'hC000, 32'h0, 32'hDEADDEAD, 1000, 0,
            4'hF, 32'h0, 1'b0, st, rq, be_done);
    chk("wd_buserr_done", 32'(be_done), 32'h1);
    chk("wd_stall_cycles", 32'(st), 32'd5);
    chk("wd_req_cycles", 32'(rq), 32'd4);
    chk("wd_readdata", ReadDataM, 32'h0);
    finish_txn();
    chk("wd_buserr_pulse", 32'(BusErrM), 32'h0);
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("wd_late_rv_readdata", ReadDataM, 32'h0);
    chk("wd_late_rv_stall", 32'(StallM), 32'h0);
`else
    // Without the watchdog a long grant delay simply stretches the stall
    run_txn(1'b1, 1'b0, 3'b010, 32'hC000, 32'h0, 32'h0F0F0F0F, 20, 0,
            4'hF, 32'h0, 1'b0, st, rq, be_done);
    chk("nowd_buserr", 32'(be_done), 32'h0);
    chk("nowd_stall_cycles", 32'(st), 32'd23);
    chk("nowd_req_cycles", 32'(rq), 32'd21);
    chk("nowd_readdata", ReadDataM, 32'h0F0F0F0F);
    finish_txn();
    chk("nowd_buserr_idle", 32'(BusErrM), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit: the consumer of the execute/memory pipeline register outputs. It turns `ALUResultM`, `WriteDataM`, `MemReadM`, `MemWriteM` and `MemCtrlM` into a request/grant/response transaction on the data-memory bus. It produces the byte-aligned, sign- or zero-extended `ReadDataM` for the memory/writeback register. It stalls the pipeline with `StallM` while a transaction is outstanding.

## Interface
- `DATA_WIDTH`, default 32, data/address width; only 32 is supported.
- `TIMEOUT_CYCLES`, default 255, watchdog limit in cycles; used only with `MEM_TIMEOUT_EN`.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ALUResultM`  in  32  byte address
- `WriteDataM`  in  32  store data, low-aligned
- `MemReadM`  in  1  load request
- `MemWriteM`  in  1  store request
- `MemCtrlM`  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 treated as W
- `mem_req`  out  1  bus request
- `mem_we`  out  1  1 = store
- `mem_addr`  out  32  word address, `{ALUResultM[31:2],2'b00}`
- `mem_wdata`  out  32  lane-replicated store data
- `mem_be`  out  4  byte enables
- `mem_gnt`  in  1  request accepted
- `mem_rvalid`  in  1  load data valid
- `mem_rdata`  in  32  load data word
- `ReadDataM`  out  32  extended load result
- `StallM`  out  1  hold the E/M register and all earlier stages
- `MisalignM`  out  1  misaligned access flag (combinational)
- `BusErrM`  out  1  watchdog timeout pulse

## Operation
- Access: `MemReadM|MemWriteM`. If both are set, the access is a load.
- Misaligned: H/HU with `addr[0]=1`, or W with `addr[1:0]≠0`.
  - `MisalignM=1` while in IDLE.
  - No bus request is issued.
  - `StallM=0`.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE → REQ when an aligned access is present. At this transition, latch `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `addr[1:0]` and `MemCtrlM`.
  - REQ: `mem_req=1`.
    - On `mem_gnt` with a store → DONE.
    - On `mem_gnt` with a load → WAIT.
    - `mem_rvalid` is ignored in REQ.
  - WAIT: on `mem_rvalid`, capture the extended `mem_rdata` into `ReadDataM`, then → DONE.
  - DONE → IDLE unconditionally. The pipeline advances at the end of the DONE cycle.
- `StallM = (IDLE & aligned access) | REQ | WAIT`.
- Store encoding:
  - SB: `be = 4'b0001<<addr[1:0]`, wdata = `{4{WriteDataM[7:0]}}`.
  - SH: `be = 4'b0011<<{addr[1],1'b0}`, wdata = `{2{WriteDataM[15:0]}}`.
  - SW: `be = 4'hF`.
- Load encoding:
  - Select the byte/half lane using the latched `addr[1:0]`.
  - B/H: sign-extend. BU/HU: zero-extend. W: pass through.
- `mem_be` and `mem_wdata` are driven for loads too (be per size); the memory ignores them.
- `ReadDataM` holds its value until the next load completes. Stores do not change it.

## Timing
- Reset (async, any state): FSM → IDLE. `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `ReadDataM`, `BusErrM` = 0. Watchdog counter = 0.
- After reset, a stray `mem_rvalid` is ignored because the FSM is in IDLE.
- Store with `gnt` in the first REQ cycle: IDLE, REQ, DONE. That is 2 stall cycles.
- Load with `gnt` in the first REQ cycle and `rvalid` one cycle later: IDLE, REQ, WAIT, DONE. That is 3 stall cycles; `ReadDataM` is valid in DONE.
- Each cycle `gnt` or `rvalid` is late adds exactly one stall cycle.
- `mem_*` outputs are registered and stable throughout REQ. `mem_req` is high only in REQ.
- No new access starts in DONE: the next instruction is evaluated in the following IDLE cycle.
- `MisalignM` and `StallM` are combinational from the current state and inputs.

## Configuration
- With `MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES` → DONE, with `BusErrM=1` for that one DONE cycle.
  - For a timed-out load, `ReadDataM=0`.
  - A late `rvalid` arriving afterwards in IDLE is ignored.
- Without `MEM_TIMEOUT_EN`: no counter; the unit waits indefinitely; `BusErrM` is tied to 0.

## Test plan
- SB, `addr=0x1003`, `WriteDataM=0x000000A5`, `gnt` in 1st REQ cycle → `mem_be=1000`, `mem_wdata=0xA5A5A5A5`, `mem_addr=0x1000`, `StallM` high 2 cycles.
- LB at `addr=0x2002`, `mem_rdata=0x1280FFFF`, `rvalid` 1 cycle after `gnt` → `ReadDataM=0xFFFFFF80` in DONE. Same with LBU → `0x00000080`.
- LH at `addr=0x3001` → `MisalignM=1`, `StallM=0`, `mem_req` stays 0.
- LW with `gnt` delayed 3 cycles and `rvalid` delayed 2 cycles → `StallM` high 7 cycles, `mem_req` high for exactly 4 cycles, `ReadDataM=mem_rdata`.
- `rst_n` low during WAIT, then `rvalid` pulse after release → FSM in IDLE, all outputs 0, `ReadDataM` stays 0.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, `gnt` never asserted → `BusErrM` pulses once, `StallM` drops, `ReadDataM=0`.
